// File: rtl/telemetry_packetizer.sv
// telemetry_packetizer: snapshots sampler, RO and clock counters plus status and streams them as a framed byte packet; define TELEMETRY_CHECKSUM_EN to insert an XOR checksum byte before the trailer
module telemetry_packetizer #(
    parameter int CS_W       = 16,
    parameter int NUM_RO     = 2,
    parameter int RO_CNT_W   = 16,
    parameter int SEL_W      = 6,
    parameter int RAND_BYTES = 1,
    parameter int WAIT_FRESH = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         cs_req,
    input  logic [CS_W-1:0]              cs_cnt,
    input  logic [NUM_RO*RO_CNT_W-1:0]   ro_cnt,
    input  logic [RO_CNT_W-1:0]          clk_cnt,
    input  logic [NUM_RO*SEL_W-1:0]      ro_sel,
    input  logic                         matched,
    input  logic                         no_found,
    input  logic [8*RAND_BYTES-1:0]      rand_bits,
    output logic [7:0]                   tx_byte,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic                         pkt_done
);
    localparam int CSB   = (CS_W + 7) / 8;
    localparam int ROB   = (RO_CNT_W + 7) / 8;
    localparam int CSX   = 8 * CSB;
    localparam int ROX   = 8 * ROB;
    localparam int NB    = 1 + CSB + (NUM_RO + 1) * ROB + NUM_RO + 1 + RAND_BYTES;
`ifdef TELEMETRY_CHECKSUM_EN
    localparam int BN    = NB + 1;
`else
    localparam int BN    = NB;
`endif
    localparam int IW    = $clog2(BN);
    localparam int O_RO  = 1 + CSB;
    localparam int O_CLK = O_RO + NUM_RO * ROB;
    localparam int O_SEL = O_CLK + ROB;
    localparam int O_ST  = O_SEL + NUM_RO;
    localparam int O_RND = O_ST + 1;

    typedef enum logic [2:0] {IDLE, WAIT_CS, HDR, BODY, TRL} state_t;

    state_t            state_q, state_d;
    logic [7:0]        body_q [BN];
    logic [7:0]        body_d [BN];
    logic [7:0]        snap   [BN];
    logic [CS_W-1:0]   cs_q, cs_d;
    logic              fresh_q, fresh_d;
    logic [7:0]        seq_q, seq_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              pkt_done_q, pkt_done_d;
    logic              acc, snap_en;
    logic [CSX-1:0]    cs_ext;
    logic [ROX-1:0]    ro_ext, clk_ext;
`ifdef TELEMETRY_CHECKSUM_EN
    logic [7:0]        chk_x;
`endif

    // Assemble the packet body from live inputs; a coincident cs_req supplies the sample directly
    always_comb begin
        snap    = '{default: 8'h00};
        cs_ext  = CSX'(cs_req ? cs_cnt : cs_q);
        clk_ext = ROX'(clk_cnt);
        ro_ext  = '0;
        snap[0] = seq_q;
        for (int j = 0; j < CSB; j++) snap[1+j] = cs_ext[8*(CSB-1-j) +: 8];
        for (int i = 0; i < NUM_RO; i++) begin
            ro_ext = ROX'(ro_cnt[i*RO_CNT_W +: RO_CNT_W]);
            for (int j = 0; j < ROB; j++) snap[O_RO+i*ROB+j] = ro_ext[8*(ROB-1-j) +: 8];
        end
        for (int j = 0; j < ROB; j++) snap[O_CLK+j] = clk_ext[8*(ROB-1-j) +: 8];
        for (int i = 0; i < NUM_RO; i++) snap[O_SEL+i] = 8'(ro_sel[i*SEL_W +: SEL_W]);
        snap[O_ST] = {matched, no_found, !(fresh_q | cs_req), 5'b0};
        for (int j = 0; j < RAND_BYTES; j++) snap[O_RND+j] = rand_bits[8*(RAND_BYTES-1-j) +: 8];
`ifdef TELEMETRY_CHECKSUM_EN
        chk_x = '0;
        for (int k = 1; k < NB; k++) chk_x = chk_x ^ snap[k];
        snap[NB] = chk_x;
`endif
    end

    // Packet sequencing: header, indexed body bytes, trailer, with next byte preloaded on accept
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        seq_d      = seq_q;
        pkt_done_d = 1'b0;
        acc        = tx_valid_q && tx_ready;
        case (state_q)
            IDLE:    if (enable) state_d = (WAIT_FRESH == 0 || fresh_q) ? HDR : WAIT_CS;
            WAIT_CS: state_d = !enable ? IDLE : (fresh_q ? HDR : WAIT_CS);
            HDR: if (acc) begin
                state_d   = BODY;
                idx_d     = '0;
                tx_byte_d = body_q[0];
            end
            BODY: if (acc) begin
                state_d   = (idx_q == IW'(BN - 1)) ? TRL : BODY;
                idx_d     = idx_q + IW'(1);
                tx_byte_d = (idx_q == IW'(BN - 1)) ? 8'hAA : body_q[idx_q + IW'(1)];
            end
            TRL: if (acc) begin
                state_d    = IDLE;
                pkt_done_d = 1'b1;
                seq_d      = seq_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        snap_en    = (state_q == IDLE || state_q == WAIT_CS) && state_d == HDR;
        tx_byte_d  = snap_en ? 8'h55 : tx_byte_d;
        tx_valid_d = state_d == HDR || state_d == BODY || state_d == TRL;
        busy_d     = tx_valid_d;
        fresh_d    = cs_req | (fresh_q & !snap_en);
        cs_d       = cs_req ? cs_cnt : cs_q;
        if (snap_en) body_d = snap;
        else body_d = body_q;
    end

    // State, snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            body_q     <= '{default: 8'h00};
            cs_q       <= '0;
            fresh_q    <= 1'b0;
            seq_q      <= '0;
            idx_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            body_q     <= body_d;
            cs_q       <= cs_d;
            fresh_q    <= fresh_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign pkt_done = pkt_done_q;
endmodule

// File: tb/tb_telemetry_packetizer.sv
// tb_telemetry_packetizer: directed checks of the default framer and a 12/1/20 WAIT_FRESH variant (TELEMETRY_CHECKSUM_EN aware)
module tb_telemetry_packetizer;
    logic        clk = 1'b0;
    logic        rst, enable, cs_req, matched, no_found, tx_ready;
    logic [15:0] cs_cnt, clk_cnt;
    logic [31:0] ro_cnt;
    logic [11:0] ro_sel;
    logic [7:0]  rand_bits;
    logic [7:0]  tx_byte;
    logic        tx_valid, busy, pkt_done;
    logic        enable2, cs_req2;
    logic [11:0] cs_cnt2;
    logic [19:0] ro_cnt2, clk_cnt2;
    logic [5:0]  ro_sel2;
    logic [7:0]  tx_byte2;
    logic        tx_valid2, busy2, pkt_done2;
    logic [7:0]  got[$];
    logic [7:0]  exp[$];
    int          checks = 0;
    int          errors = 0;
    int          bubbles;
    int          first, gap;
    bit          ok;

    always #5 clk = ~clk;

    telemetry_packetizer dut (
        .clk(clk), .rst(rst), .enable(enable), .cs_req(cs_req), .cs_cnt(cs_cnt),
        .ro_cnt(ro_cnt), .clk_cnt(clk_cnt), .ro_sel(ro_sel), .matched(matched),
        .no_found(no_found), .rand_bits(rand_bits), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .pkt_done(pkt_done)
    );

    telemetry_packetizer #(.CS_W(12), .NUM_RO(1), .RO_CNT_W(20), .WAIT_FRESH(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .cs_req(cs_req2), .cs_cnt(cs_cnt2),
        .ro_cnt(ro_cnt2), .clk_cnt(clk_cnt2), .ro_sel(ro_sel2), .matched(matched),
        .no_found(no_found), .rand_bits(rand_bits), .tx_byte(tx_byte2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready), .busy(busy2), .pkt_done(pkt_done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    // Append the checksum byte before the trailer when the build carries it
    task automatic finish_exp();
`ifdef TELEMETRY_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 1; i < exp.size() - 1; i++) x ^= exp[i];
        exp.insert(exp.size() - 1, x);
`endif
    endtask

    task automatic check_pkt(input string tag, input int mask);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            if (i != mask) chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    endtask

    // Collect one packet byte-by-byte; optional stall, optional mid-packet input scramble
    task automatic capture(input bit sel, input int stall_at, input bit scramble,
                           output int first_c, output int gap_c, output bit done);
        int   last = -1;
        logic [7:0] held;
        got.delete();
        done = 0; first_c = -1; gap_c = -1; bubbles = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            cs_req = 1'b0; cs_req2 = 1'b0;
            if (sel ? pkt_done2 : pkt_done) begin
                done = 1; gap_c = c - last;
            end else if (sel ? tx_valid2 : tx_valid) begin
                if (first_c < 0) begin
                    first_c = c;
                    if (sel) enable2 = 1'b0; else enable = 1'b0;
                    if (scramble) begin
                        ro_cnt = '0; clk_cnt = '0; cs_cnt = '0; rand_bits = '0; matched = 1'b0; ro_sel = '0;
                    end
                end
                if (got.size() == stall_at) begin
                    held = tx_byte;
                    tx_ready = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1; c++;
                        chk("stall_valid", {31'h0, tx_valid}, 32'h1);
                        chk("stall_hold", {24'h0, tx_byte}, {24'h0, held});
                    end
                    tx_ready = 1'b1;
                end
                got.push_back(sel ? tx_byte2 : tx_byte);
                last = c;
            end else if (first_c >= 0) bubbles++;
        end
        chk("pkt_timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic restore();
        cs_cnt = 16'h0F0F; ro_cnt = 32'hBBBB_AAAA; clk_cnt = 16'hC0DE;
        ro_sel = {6'h2A, 6'h15}; matched = 1'b1; rand_bits = 8'h5A;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cs_req = 1'b0; tx_ready = 1'b1; no_found = 1'b0;
        enable2 = 1'b0; cs_req2 = 1'b0; cs_cnt2 = '0; ro_cnt2 = '0; clk_cnt2 = '0; ro_sel2 = '0;
        cs_cnt = 16'h1234; ro_cnt = 32'hBBBB_AAAA; clk_cnt = 16'hC0DE;
        ro_sel = {6'h2A, 6'h15}; matched = 1'b1; rand_bits = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, pkt_done}, 32'h0);
        chk("rst_byte", {24'h0, tx_byte}, 32'h0);
        rst = 1'b0;
        cs_req = 1'b1;
        @(posedge clk); #1;
        cs_req = 1'b0;

        // Packet 1: fresh sample, no stalls
        enable = 1'b1;
        capture(0, -1, 0, first, gap, ok);
        exp = '{8'h55, 8'h00, 8'h12, 8'h34, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hC0, 8'hDE, 8'h15, 8'h2A, 8'h80, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("p1", -1);
        chk("p1_latency", first, 0);
        chk("p1_done_gap", gap, 1);
        chk("p1_bubbles", bubbles, 0);
        @(posedge clk); #1;
        chk("p1_done_pulse", {31'h0, pkt_done}, 32'h0);
        chk("p1_idle_busy", {31'h0, busy}, 32'h0);

        // Packet 2: stale, stalled on the fourth byte
        enable = 1'b1;
        capture(0, 3, 0, first, gap, ok);
        exp = '{8'h55, 8'h01, 8'h12, 8'h34, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hC0, 8'hDE, 8'h15, 8'h2A, 8'hA0, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("p2", -1);
        chk("p2_bubbles", bubbles, 0);

        // Packet 3: cs_req on the snapshot edge
        cs_cnt = 16'h0F0F; cs_req = 1'b1; enable = 1'b1;
        capture(0, -1, 0, first, gap, ok);
        exp = '{8'h55, 8'h02, 8'h0F, 8'h0F, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hC0, 8'hDE, 8'h15, 8'h2A, 8'h00, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("p3", (exp.size() == 15 || exp.size() == 16) ? 12 : -1);

        // Packet 4: not stale; inputs scrambled mid-packet must not leak in
        enable = 1'b1;
        capture(0, -1, 1, first, gap, ok);
        exp = '{8'h55, 8'h03, 8'h0F, 8'h0F, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hC0, 8'hDE, 8'h15, 8'h2A, 8'h80, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("p4", -1);
        restore();

        // Packet 5: reset at byte 6
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("p5_b6", {24'h0, tx_byte}, 32'hAA);
        chk("p5_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("p5_rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("p5_rst_busy", {31'h0, busy}, 32'h0);
        chk("p5_rst_byte", {24'h0, tx_byte}, 32'h0);

        // Packet 6: SEQ and CS register restarted by reset
        enable = 1'b1;
        capture(0, -1, 0, first, gap, ok);
        exp = '{8'h55, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hC0, 8'hDE, 8'h15, 8'h2A, 8'hA0, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("p6", -1);

        // SEQ runs 1..255 then wraps to 0
        for (int k = 1; k <= 256; k++) begin
            enable = 1'b1;
            capture(0, -1, 0, first, gap, ok);
            if (got.size() > 1) chk($sformatf("wrap_seq%0d", k), {24'h0, got[1]}, k & 32'hFF);
            else chk("wrap_len", got.size(), exp.size());
        end

        // Second configuration: waits for a fresh sample
        enable2 = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("wf_hold_valid", {31'h0, tx_valid2}, 32'h0);
        end
        chk("wf_hold_busy", {31'h0, busy2}, 32'h0);
        cs_cnt2 = 12'hABC; ro_cnt2 = 20'hABCDE; clk_cnt2 = 20'h12345; ro_sel2 = 6'h3F;
        cs_req2 = 1'b1;
        capture(1, -1, 0, first, gap, ok);
        chk("wf_first", first, 1);
        exp = '{8'h55, 8'h00, 8'h0A, 8'hBC, 8'h0A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45, 8'h3F, 8'h80, 8'h5A, 8'hAA};
        finish_exp();
        check_pkt("cfg2", -1);
`ifdef TELEMETRY_CHECKSUM_EN
        chk("cfg2_len15", got.size(), 15);
        if (got.size() > 13) chk("cfg2_chk", {24'h0, got[13]}, 32'h5C);
`else
        chk("cfg2_len14", got.size(), 14);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/telemetry_packetizer.md
Name: telemetry_packetizer

Overview:
- Parametrised debug-mode packet framer.
- Snapshots coherent-sampler, ring-oscillator and clock counters, RO configuration, controller status and random bytes, then serialises them as a framed byte stream to the UART transmitter.
- Uses a valid/ready byte handshake.
- Supports any RO count and counter width, carries a sequence number and a stale-sample flag, and can optionally wait for a fresh CS sample.

Parameters:
- CS_W, 16: coherent-sampler counter width (1..32).
- NUM_RO, 2: number of RO counters and select fields (1..4).
- RO_CNT_W, 16: width of each RO counter and of the clock counter (1..32).
- SEL_W, 6: width of each RO select field (1..8).
- RAND_BYTES, 1: random bytes per packet (1..4).
- WAIT_FRESH, 0: 1 = hold packet start until a cs_req has occurred since the previous snapshot.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- enable, in, 1: start packets while high.
- cs_req, in, 1: CS counter stable strobe.
- cs_cnt, in, CS_W: CS counter value.
- ro_cnt, in, NUM_RO*RO_CNT_W: RO counters; RO i occupies bits [i*RO_CNT_W +: RO_CNT_W].
- clk_cnt, in, RO_CNT_W: clock counter.
- ro_sel, in, NUM_RO*SEL_W: RO selects, packed the same way as ro_cnt.
- matched, in, 1: configuration found.
- no_found, in, 1: configuration search failed.
- rand_bits, in, 8*RAND_BYTES: random data.
- tx_byte, out, 8: byte to transmit.
- tx_valid, out, 1: tx_byte valid.
- tx_ready, in, 1: transmitter accepts tx_byte.
- busy, out, 1: packet in progress.
- pkt_done, out, 1: one-cycle pulse after trailer is accepted.

Behaviour:
- Reset values: tx_byte=0, tx_valid=0, busy=0, pkt_done=0. Sequence counter, cs register and fresh flag are also cleared.
- CS capture: on cs_req, cs_cnt is latched into cs_reg and the fresh flag is set.
- Field sizing and order:
  - CSB = ceil(CS_W/8), ROB = ceil(RO_CNT_W/8).
  - Multi-byte fields are sent MSB-first and zero-padded at the top.
- Packet byte order:
  - 0x55
  - SEQ
  - CS (CSB bytes)
  - RO0..RO(NUM_RO-1) (ROB bytes each)
  - CLK (ROB bytes)
  - SEL0..SEL(NUM_RO-1), one byte each, zero-padded
  - STATUS = {matched, no_found, stale, 5'b0}
  - RAND, MS byte first
  - [CHK]
  - 0xAA
- Packet length at defaults: 15 bytes, or 16 with CHK.
- FSM states:
  - IDLE: when enable=1, go to HDR if WAIT_FRESH=0 or fresh=1; otherwise go to WAIT_CS.
  - WAIT_CS: go to HDR on the first cycle fresh=1.
  - HDR: present 0x55; on accept, go to BODY.
  - BODY: a byte index steps through the remaining fields; after the last body byte, go to TRL.
  - TRL: present 0xAA; on accept, pulse pkt_done and go to IDLE.
- Snapshot:
  - Taken on the edge entering HDR, the same edge tx_valid rises.
  - All inputs are registered at that edge; stale = !fresh; fresh is cleared.
  - If cs_req coincides with the snapshot edge, the snapshot takes cs_cnt directly, and fresh ends set (the sample counts for the next packet as well).
- Handshake:
  - A byte transfers on a clk edge with tx_valid & tx_ready.
  - tx_byte is stable while tx_valid & !tx_ready.
  - The next byte is presented the cycle after acceptance: no bubble, tx_valid stays high through the packet.
  - tx_valid is low in IDLE and WAIT_CS.
- First byte latency: 1 cycle from enable in IDLE (WAIT_FRESH=0).
- busy: high from HDR through TRL inclusive.
- SEQ: 8-bit, increments on pkt_done, wraps 0xFF->0x00.
- enable deasserted mid-packet: current packet completes; no new packet starts.
- enable low in WAIT_CS: return to IDLE.
- rst mid-packet: outputs take reset values next cycle; the partial packet is abandoned and SEQ restarts at 0.
- Inputs changing mid-packet do not affect the packet being sent.

Optional Feature:
- Macro: TELEMETRY_CHECKSUM_EN.
- Defined: a CHK byte is inserted before 0xAA. CHK = XOR of all bytes from SEQ through the last RAND byte. Packet length grows by 1.
- Undefined: no CHK byte; no checksum logic.

Test Plan:
- Defaults, tx_ready=1, cs_req with cs_cnt=0x1234, ro_cnt={0xBBBB,0xAAAA}, clk_cnt=0xC0DE, ro_sel={6'h2A,6'h15}, matched=1, rand=0x5A, then enable -> stream 55 00 12 34 AA AA BB BB C0 DE 15 2A 80 5A AA, pkt_done one cycle after the final byte.
- tx_ready stalled 3 cycles on byte 4 -> tx_byte holds 0x34 with tx_valid=1; the stream is otherwise identical.
- Second packet with no intervening cs_req -> SEQ=0x01, STATUS=0xA0 (stale set); WAIT_FRESH=1 -> tx_valid stays 0 until cs_req, then header on the next cycle.
- cs_req with cs_cnt=0x0F0F on the snapshot edge -> CS bytes 0F 0F; the following packet is not stale.
- rst asserted at byte 6 -> tx_valid=0, busy=0 next cycle; the next packet carries SEQ=0x00. Run 256 packets -> SEQ wraps to 0x00.
- CS_W=12, NUM_RO=1, RO_CNT_W=20, TELEMETRY_CHECKSUM_EN defined -> CS 0x0ABC sent as 0A BC, RO sent as 3 bytes, packet length 15, CHK equals XOR of bytes 2..13.
